// File: rtl/alu_cu_pkg.sv
// alu_cu_pkg: shared ALU control codes, funct/ALUOp constants and sequencer state type
package alu_cu_pkg;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_SUBI  = 2'b11;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} md_state_e;
  // MULT/MULTU/DIV/DIVU share funct[5:2]; funct[1] selects divide, funct[0] unsigned
  function automatic logic is_md(input logic [5:0] f);
    return f[5:2] == F_MULT[5:2];
  endfunction
endpackage

// File: rtl/alu_cu_md_if.sv
// alu_cu_md_if: ID/EX-side bus of the ALU control unit with master (pipeline) and slave (control unit) views
interface alu_cu_md_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);
  logic              valid_i;
  logic [1:0]        ALUOp;
  logic [5:0]        funct;
  logic [WIDTH-1:0]  rs_val;
  logic [WIDTH-1:0]  rt_val;
  logic [CTRL_W-1:0] ALU_Control;
  logic [1:0]        hilo_sel;
  logic              stall;
  logic              md_busy;
  logic              md_done;
  logic [WIDTH-1:0]  hi_o;
  logic [WIDTH-1:0]  lo_o;
  modport master (
    output valid_i, ALUOp, funct, rs_val, rt_val,
    input  ALU_Control, hilo_sel, stall, md_busy, md_done, hi_o, lo_o
  );
  modport slave (
    input  valid_i, ALUOp, funct, rs_val, rt_val,
    output ALU_Control, hilo_sel, stall, md_busy, md_done, hi_o, lo_o
  );
endinterface

// File: rtl/md_seq_core.sv
// md_seq_core: iterative shift-add multiply / restoring divide sequencer owning HI/LO (ALU_CU_FAST_MUL_EN: single-cycle multiply)
module md_seq_core
  import alu_cu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  md_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] a, b, acc_hi, acc_lo, hacc_nxt, lacc_nxt, abs_a, abs_b, dif;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH:0] msum, dsh;
  logic sgn, sa, sb, neg_p, neg_r, dz, ld, wr, borrow;
  assign sgn   = ~op[0];
  assign sa    = sgn & rs[WIDTH-1];
  assign sb    = sgn & rt[WIDTH-1];
  assign abs_a = sa ? -rs : rs;
  assign abs_b = sb ? -rt : rt;
  assign msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a} : '0);
  assign dsh   = {acc_hi, acc_lo[WIDTH-1]};
  assign borrow = dsh < {1'b0, b};
  assign dif   = dsh[WIDTH-1:0] - b;
  assign busy  = state != IDLE;
  assign done  = state == FIN;
`ifdef ALU_CU_FAST_MUL_EN
  logic signed [WIDTH:0] xa, xb;
  logic signed [2*WIDTH+1:0] xp;
  assign xa = {sa, rs};
  assign xb = {sb, rt};
  assign xp = xa * xb;
`endif
  // next state, one iteration step, and the sign-corrected result written on the last step
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hacc_nxt  = acc_hi;
    lacc_nxt  = acc_lo;
    res       = {hi, lo};
    ld        = 1'b0;
    wr        = 1'b0;
    case (state)
      IDLE: if (start) begin
        ld        = 1'b1;
        cnt_nxt   = CNT_W'(WIDTH);
        hacc_nxt  = '0;
        lacc_nxt  = op[1] ? abs_a : abs_b;
        state_nxt = op[1] ? DIV : MUL;
`ifdef ALU_CU_FAST_MUL_EN
        if (!op[1]) begin
          state_nxt = FIN;
          cnt_nxt   = '0;
          wr        = 1'b1;
          res       = xp[2*WIDTH-1:0];
        end
`endif
      end
      MUL: begin
        hacc_nxt  = msum[WIDTH:1];
        lacc_nxt  = {msum[0], acc_lo[WIDTH-1:1]};
        cnt_nxt   = cnt - CNT_W'(1);
        wr        = cnt == CNT_W'(1);
        state_nxt = wr ? FIN : MUL;
        res       = neg_p ? -{hacc_nxt, lacc_nxt} : {hacc_nxt, lacc_nxt};
      end
      DIV: begin
        hacc_nxt  = borrow ? dsh[WIDTH-1:0] : dif;
        lacc_nxt  = {acc_lo[WIDTH-2:0], ~borrow};
        cnt_nxt   = cnt - CNT_W'(1);
        wr        = cnt == CNT_W'(1);
        state_nxt = wr ? FIN : DIV;
        res       = {neg_r ? -hacc_nxt : hacc_nxt, dz ? {WIDTH{1'b1}} : (neg_p ? -lacc_nxt : lacc_nxt)};
      end
      default: state_nxt = IDLE;
    endcase
  end
  // sequencer registers; magnitudes and result signs are latched on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a      <= '0;
      b      <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg_p  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      acc_hi <= hacc_nxt;
      acc_lo <= lacc_nxt;
      if (ld) begin
        a     <= abs_a;
        b     <= abs_b;
        neg_p <= sa ^ sb;
        neg_r <= sa;
        dz    <= ~|rt;
      end
      if (wr) {hi, lo} <= res;
    end
  end
endmodule

// File: rtl/alu_cu_md.sv
// alu_cu_md: ALU control decode, MD sequencer launch, dependency stall and HI/LO select (option: ALU_CU_FAST_MUL_EN)
module alu_cu_md
  import alu_cu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  alu_cu_md_if.slave bus
);
  logic rtype, md, mfhi, mflo, start;
  logic [3:0] code;
  assign rtype = bus.ALUOp == OP_RTYPE;
  assign md    = rtype & is_md(bus.funct);
  assign mfhi  = rtype & (bus.funct == F_MFHI);
  assign mflo  = rtype & (bus.funct == F_MFLO);
  assign start = bus.valid_i & md & ~bus.md_busy;
  assign bus.stall       = bus.valid_i & bus.md_busy & (md | mfhi | mflo);
  assign bus.hilo_sel    = {bus.valid_i & mflo, bus.valid_i & mfhi};
  assign bus.ALU_Control = CTRL_W'(code);
  // ALU control code, purely from ALUOp/funct
  always_comb begin
    code = ALU_AND;
    if (bus.ALUOp != OP_RTYPE) code = (bus.ALUOp == OP_ADD) ? ALU_ADD : ALU_SUB;
    else
      case (bus.funct)
        F_ADD:   code = ALU_ADD;
        F_SUB:   code = ALU_SUB;
        F_AND:   code = ALU_AND;
        F_OR:    code = ALU_OR;
        F_XOR:   code = ALU_XOR;
        F_NOR:   code = ALU_NOR;
        F_SLT:   code = ALU_SLT;
        F_SLTU:  code = ALU_SLTU;
        default: code = ALU_AND;
      endcase
  end
  md_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (bus.funct[1:0]),
    .rs    (bus.rs_val),
    .rt    (bus.rt_val),
    .busy  (bus.md_busy),
    .done  (bus.md_done),
    .hi    (bus.hi_o),
    .lo    (bus.lo_o)
  );
endmodule

// File: tb/tb_alu_cu_md.sv
// tb_alu_cu_md: directed self-checking bench for alu_cu_md (WIDTH = 32, default build)
module tb_alu_cu_md;
  import alu_cu_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  alu_cu_md_if bus ();
  alu_cu_md dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic idle_bus();
    bus.valid_i = 1'b0;
    bus.ALUOp   = OP_ADD;
    bus.funct   = '0;
    bus.rs_val  = '0;
    bus.rt_val  = '0;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
    bus.valid_i = 1'b1;
    bus.ALUOp   = OP_RTYPE;
    bus.funct   = f;
    bus.rs_val  = rs;
    bus.rt_val  = rt;
  endtask

  // presents an MD op for one cycle; returns cycles from accept to md_done (-1 on timeout)
  task automatic run_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt, output int lat);
    @(negedge clk);
    drive(f, rs, rt);
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) idle_bus();
      #1;
      if (bus.md_done) lat = k;
    end
  endtask

  task automatic test_reset();
    idle_bus();
    repeat (2) @(negedge clk);
    drive(F_MULT, 32'd3, 32'd4);
    #1;
    n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.hi_o, 32'h0); end
    n_checks++; if (bus.lo_o !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.lo_o, 32'h0); end
    n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.md_busy); end
    n_checks++; if (bus.md_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.md_done); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy: got %b expected 0", bus.md_busy); end
    idle_bus();
    rst_n = 1'b1;
  endtask

  task automatic test_decode();
    logic [11:0] vec [12];
    vec = '{
      {2'b00, 6'b000000, 4'b0010}, {2'b01, 6'b100000, 4'b0110}, {2'b11, 6'b101010, 4'b0110},
      {2'b10, 6'b100000, 4'b0010}, {2'b10, 6'b100010, 4'b0110}, {2'b10, 6'b100100, 4'b0000},
      {2'b10, 6'b100101, 4'b0001}, {2'b10, 6'b100110, 4'b0011}, {2'b10, 6'b100111, 4'b1100},
      {2'b10, 6'b101010, 4'b0111}, {2'b10, 6'b101011, 4'b1000}, {2'b10, 6'b111111, 4'b0000}
    };
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.ALUOp   = vec[i][11:10];
      bus.funct   = vec[i][9:4];
      #1;
      n_checks++;
      if (bus.ALU_Control !== vec[i][3:0]) begin
        n_fail++;
        $display("FAIL decode_%0d (op %b funct %b): got %b expected %b", i, vec[i][11:10], vec[i][9:4], bus.ALU_Control, vec[i][3:0]);
      end
    end
    @(negedge clk);
    drive(F_MFHI, 32'h0, 32'h0);
    #1;
    n_checks++; if (bus.hilo_sel !== 2'b01) begin n_fail++; $display("FAIL hilo_mfhi: got %b expected 01", bus.hilo_sel); end
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL idle_mfhi_stall: got %b expected 0", bus.stall); end
    bus.funct = F_MFLO;
    #1;
    n_checks++; if (bus.hilo_sel !== 2'b10) begin n_fail++; $display("FAIL hilo_mflo: got %b expected 10", bus.hilo_sel); end
    bus.valid_i = 1'b0;
    #1;
    n_checks++; if (bus.hilo_sel !== 2'b00) begin n_fail++; $display("FAIL hilo_invalid: got %b expected 00", bus.hilo_sel); end
    bus.valid_i = 1'b1;
    bus.ALUOp   = OP_ADD;
    #1;
    n_checks++; if (bus.hilo_sel !== 2'b00) begin n_fail++; $display("FAIL hilo_not_rtype: got %b expected 00", bus.hilo_sel); end
    idle_bus();
  endtask

  task automatic test_mult();
    int lat;
    run_md(F_MULT, 32'hFFFFFFFD, 32'd7, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected %h", bus.hi_o, 32'hFFFFFFFF); end
    n_checks++; if (bus.lo_o !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mult_lo: got %h expected %h", bus.lo_o, 32'hFFFFFFEB); end
    n_checks++; if (bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL done_cycle_busy: got %b expected 1", bus.md_busy); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL after_done_busy: got %b expected 0", bus.md_busy); end
    n_checks++; if (bus.md_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b expected 0", bus.md_done); end
    run_md(F_MULTU, 32'hFFFFFFFF, 32'd2, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.hi_o !== 32'h1) begin n_fail++; $display("FAIL multu_hi: got %h expected %h", bus.hi_o, 32'h1); end
    n_checks++; if (bus.lo_o !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected %h", bus.lo_o, 32'hFFFFFFFE); end
  endtask

  task automatic test_div();
    int lat;
    run_md(F_DIV, 32'hFFFFFFF9, 32'd2, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.lo_o !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_quot: got %h expected %h", bus.lo_o, 32'hFFFFFFFD); end
    n_checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_rem: got %h expected %h", bus.hi_o, 32'hFFFFFFFF); end
    run_md(F_DIV, 32'd7, 32'hFFFFFFFE, lat);
    n_checks++; if (bus.lo_o !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_negdiv_quot: got %h expected %h", bus.lo_o, 32'hFFFFFFFD); end
    n_checks++; if (bus.hi_o !== 32'h1) begin n_fail++; $display("FAIL div_negdiv_rem: got %h expected %h", bus.hi_o, 32'h1); end
    run_md(F_DIVU, 32'd7, 32'd0, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_zero_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.lo_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu_zero_lo: got %h expected %h", bus.lo_o, 32'hFFFFFFFF); end
    n_checks++; if (bus.hi_o !== 32'h7) begin n_fail++; $display("FAIL divu_zero_hi: got %h expected %h", bus.hi_o, 32'h7); end
    run_md(F_DIV, 32'hFFFFFFF9, 32'd0, lat);
    n_checks++; if (bus.lo_o !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_zero_lo: got %h expected %h", bus.lo_o, 32'hFFFFFFFF); end
    n_checks++; if (bus.hi_o !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL div_zero_hi: got %h expected %h", bus.hi_o, 32'hFFFFFFF9); end
    run_md(F_DIV, 32'h80000000, 32'hFFFFFFFF, lat);
    n_checks++; if (bus.lo_o !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected %h", bus.lo_o, 32'h80000000); end
    n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected %h", bus.hi_o, 32'h0); end
  endtask

  task automatic test_stall();
    int done_k = -1;
    int drop = -1;
    logic stall_at_done = 1'b0;
    @(negedge clk);
    drive(F_DIV, 32'd100, 32'd7);
    @(negedge clk);
    drive(F_MFLO, 32'h0, 32'h0);
    #1;
    n_checks++; if (bus.md_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b expected 1", bus.md_busy); end
    for (int k = 1; k <= 60 && drop < 0; k++) begin
      if (k > 1) begin
        @(negedge clk);
        #1;
      end
      if (bus.md_done) begin
        done_k = k;
        stall_at_done = bus.stall;
      end
      if (!bus.stall) drop = k;
    end
    n_checks++; if (done_k !== 33) begin n_fail++; $display("FAIL stall_done_cycle: got %0d expected 33", done_k); end
    n_checks++; if (stall_at_done !== 1'b1) begin n_fail++; $display("FAIL stall_in_done_cycle: got %b expected 1", stall_at_done); end
    n_checks++; if (drop !== 34) begin n_fail++; $display("FAIL stall_release: got %0d expected 34", drop); end
    n_checks++; if (bus.hilo_sel !== 2'b10) begin n_fail++; $display("FAIL mflo_sel: got %b expected 10", bus.hilo_sel); end
    n_checks++; if (bus.lo_o !== 32'd14) begin n_fail++; $display("FAIL mflo_quot: got %h expected %h", bus.lo_o, 32'd14); end
    n_checks++; if (bus.hi_o !== 32'd2) begin n_fail++; $display("FAIL mflo_rem: got %h expected %h", bus.hi_o, 32'd2); end
    idle_bus();
  endtask

  task automatic test_back_to_back();
    int drop = -1;
    int lat = -1;
    @(negedge clk);
    drive(F_DIVU, 32'd9, 32'd2);
    @(negedge clk);
    bus.valid_i = 1'b1;
    bus.ALUOp   = OP_RTYPE;
    bus.funct   = F_ADD;
    #1;
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL add_while_busy_stall: got %b expected 0", bus.stall); end
    drive(F_MULTU, 32'd3, 32'd4);
    for (int k = 1; k <= 60 && drop < 0; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (!bus.stall) drop = k;
    end
    n_checks++; if (drop !== 34) begin n_fail++; $display("FAIL b2b_release: got %0d expected 34", drop); end
    n_checks++; if (bus.lo_o !== 32'd4) begin n_fail++; $display("FAIL b2b_first_quot: got %h expected %h", bus.lo_o, 32'd4); end
    n_checks++; if (bus.hi_o !== 32'd1) begin n_fail++; $display("FAIL b2b_first_rem: got %h expected %h", bus.hi_o, 32'd1); end
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1) idle_bus();
      #1;
      if (bus.md_done) lat = k;
    end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.lo_o !== 32'd12) begin n_fail++; $display("FAIL b2b_second_lo: got %h expected %h", bus.lo_o, 32'd12); end
    n_checks++; if (bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL b2b_second_hi: got %h expected %h", bus.hi_o, 32'd0); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    drive(F_MULT, 32'd123, 32'd456);
    @(negedge clk);
    idle_bus();
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.hi_o !== 32'h0) begin n_fail++; $display("FAIL midreset_hi: got %h expected %h", bus.hi_o, 32'h0); end
    n_checks++; if (bus.lo_o !== 32'h0) begin n_fail++; $display("FAIL midreset_lo: got %h expected %h", bus.lo_o, 32'h0); end
    n_checks++; if (bus.md_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", bus.md_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    run_md(F_MULTU, 32'd5, 32'd6, lat);
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 33", lat); end
    n_checks++; if (bus.lo_o !== 32'd30) begin n_fail++; $display("FAIL post_reset_lo: got %h expected %h", bus.lo_o, 32'd30); end
    n_checks++; if (bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL post_reset_hi: got %h expected %h", bus.hi_o, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
